// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Purpose:
//   Receiving end of the fetch interface. An IF/ID register captures the
//   instruction word, 26-bit control bundle and sequential PC from fetch.
//   Register and immediate fields are extracted from the IF/ID word and
//   registered, together with the bundle and PC, into an ID/EX register
//   that drives execute. Load-use hazards against the instruction in
//   ID/EX stall fetch for one cycle and insert a bubble. Flushes for taken
//   branches and jumps resolved in EX kill both younger stages. A
//   saturating counter tracks load-use stall cycles.
//
// Fetch handshake:
//   Fetch always presents a word (instruction_in/bundle_in/pc_seq_in).
//   pc_enable_out is the ready: a word is accepted into IF/ID on a rising
//   edge where pc_enable_out=1 and flush_in=0. When pc_enable_out=0 fetch
//   must keep presenting the same word. A flush discards whatever fetch
//   presents on that edge; fetch redirects via its own next-PC path.
//
// Ports:
//   clk              in   rising-edge clock
//   reset            in   asynchronous, active-high reset
//   instruction_in   in   [31:0] instruction word from fetch
//   bundle_in        in   [25:0] control bundle from fetch (bit 2 = data_mem_re)
//   pc_seq_in        in   [31:0] PC+4 from fetch
//   flush_in         in   kill younger instructions (taken branch/jump in EX)
//   pc_enable_out    out  fetch PC/ROM advance enable
//   instruction_out  out  [31:0] ID/EX instruction
//   bundle_out       out  [25:0] ID/EX control bundle
//   pc_seq_out       out  [31:0] ID/EX PC+4
//   rs_out           out  [4:0]  field [25:21]
//   rt_out           out  [4:0]  field [20:16]
//   rd_out           out  [4:0]  field [15:11]
//   shamt_out        out  [4:0]  field [10:6]
//   imm_out          out  [15:0] field [15:0]
//   valid_out        out  ID/EX holds a real instruction
//   stall_count_out  out  [STALL_CNT_WIDTH-1:0] saturating load-use stall count
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter logic [31:0] NOP_INSTR       = 32'h3400_0000,
    parameter int          STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                instruction_in,
    input  logic [25:0]                bundle_in,
    input  logic [31:0]                pc_seq_in,
    input  logic                       flush_in,
    output logic                       pc_enable_out,
    output logic [31:0]                instruction_out,
    output logic [25:0]                bundle_out,
    output logic [31:0]                pc_seq_out,
    output logic [4:0]                 rs_out,
    output logic [4:0]                 rt_out,
    output logic [4:0]                 rd_out,
    output logic [4:0]                 shamt_out,
    output logic [15:0]                imm_out,
    output logic                       valid_out,
    output logic [STALL_CNT_WIDTH-1:0] stall_count_out
);

    // Fields of the bubble word, used for reset and bubble insertion.
    localparam logic [4:0]  NOP_RS    = NOP_INSTR[25:21];
    localparam logic [4:0]  NOP_RT    = NOP_INSTR[20:16];
    localparam logic [4:0]  NOP_RD    = NOP_INSTR[15:11];
    localparam logic [4:0]  NOP_SHAMT = NOP_INSTR[10:6];
    localparam logic [15:0] NOP_IMM   = NOP_INSTR[15:0];

    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = '1;
    localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_ONE =
        {{(STALL_CNT_WIDTH-1){1'b0}}, 1'b1};

    // Bundle bit that marks a load (data memory read).
    localparam int BUNDLE_MEM_RE = 2;

    // What the pipeline registers do on the coming edge, in priority order.
    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_FLUSH   = 2'd2
    } action_t;

    // -----------------------------------------------------------------------
    // IF/ID register
    // -----------------------------------------------------------------------
    logic [31:0] fd_instr;
    logic [25:0] fd_bundle;
    logic [31:0] fd_pc;
    logic        fd_valid;

    // -----------------------------------------------------------------------
    // ID/EX register
    // -----------------------------------------------------------------------
    logic [31:0] ex_instr;
    logic [25:0] ex_bundle;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_shamt;
    logic [15:0] ex_imm;
    logic        ex_valid;

    logic [STALL_CNT_WIDTH-1:0] stall_cnt;

    // -----------------------------------------------------------------------
    // Field decode from the IF/ID word
    // -----------------------------------------------------------------------
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic [4:0]  dec_rd;
    logic [4:0]  dec_shamt;
    logic [15:0] dec_imm;

    always_comb begin
        dec_rs    = fd_instr[25:21];
        dec_rt    = fd_instr[20:16];
        dec_rd    = fd_instr[15:11];
        dec_shamt = fd_instr[10:6];
        dec_imm   = fd_instr[15:0];
    end

    // -----------------------------------------------------------------------
    // Load-use hazard
    // The rt match is made for every instruction, whether or not it really
    // reads rt: a spurious one-cycle stall is cheaper than decoding the
    // opcode here. A load into $zero never produces a value worth waiting
    // for, so it never stalls.
    // -----------------------------------------------------------------------
    logic hazard;
    logic rt_is_src;

    always_comb begin
        rt_is_src = (ex_rt == dec_rs) || (ex_rt == dec_rt);
        hazard    = fd_valid && ex_valid && ex_bundle[BUNDLE_MEM_RE] &&
                    (ex_rt != 5'd0) && rt_is_src;
    end

    // Fetch keeps advancing during a flush; it loads the redirect target.
    assign pc_enable_out = ~hazard & ~reset;

    action_t action;

    always_comb begin
        action = ACT_ADVANCE;
        if (flush_in) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_STALL;
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fd_instr  <= NOP_INSTR;
            fd_bundle <= 26'd0;
            fd_pc     <= 32'd0;
            fd_valid  <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH: begin
                    fd_instr  <= NOP_INSTR;
                    fd_bundle <= 26'd0;
                    fd_pc     <= 32'd0;
                    fd_valid  <= 1'b0;
                end
                ACT_STALL: begin
                    // Hold: the dependent instruction retries next cycle.
                    fd_instr  <= fd_instr;
                    fd_bundle <= fd_bundle;
                    fd_pc     <= fd_pc;
                    fd_valid  <= fd_valid;
                end
                default: begin
                    fd_instr  <= instruction_in;
                    fd_bundle <= bundle_in;
                    fd_pc     <= pc_seq_in;
                    fd_valid  <= 1'b1;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // ID/EX update
    // A bubble clears the bundle, so the load that caused a stall no longer
    // looks like a load on the next cycle and the stall lasts one cycle.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_instr  <= NOP_INSTR;
            ex_bundle <= 26'd0;
            ex_pc     <= 32'd0;
            ex_rs     <= NOP_RS;
            ex_rt     <= NOP_RT;
            ex_rd     <= NOP_RD;
            ex_shamt  <= NOP_SHAMT;
            ex_imm    <= NOP_IMM;
            ex_valid  <= 1'b0;
        end else begin
            case (action)
                ACT_FLUSH, ACT_STALL: begin
                    ex_instr  <= NOP_INSTR;
                    ex_bundle <= 26'd0;
                    ex_pc     <= 32'd0;
                    ex_rs     <= NOP_RS;
                    ex_rt     <= NOP_RT;
                    ex_rd     <= NOP_RD;
                    ex_shamt  <= NOP_SHAMT;
                    ex_imm    <= NOP_IMM;
                    ex_valid  <= 1'b0;
                end
                default: begin
                    ex_instr  <= fd_instr;
                    ex_bundle <= fd_bundle;
                    ex_pc     <= fd_pc;
                    ex_rs     <= dec_rs;
                    ex_rt     <= dec_rt;
                    ex_rd     <= dec_rd;
                    ex_shamt  <= dec_shamt;
                    ex_imm    <= dec_imm;
                    ex_valid  <= fd_valid;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Saturating stall counter: counts load-use stall cycles only; a flush
    // that wins over a hazard is not a stall.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if ((action == ACT_STALL) && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + STALL_CNT_ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign instruction_out = ex_instr;
    assign bundle_out      = ex_bundle;
    assign pc_seq_out      = ex_pc;
    assign rs_out          = ex_rs;
    assign rt_out          = ex_rt;
    assign rd_out          = ex_rd;
    assign shamt_out       = ex_shamt;
    assign imm_out         = ex_imm;
    assign valid_out       = ex_valid;
    assign stall_count_out = stall_cnt;

endmodule

// File: tb/tb_decode_stage.sv
`timescale 1ns/1ps
module tb_decode_stage;

    localparam logic [31:0] NOP   = 32'h3400_0000;
    localparam logic [31:0] ADD1  = 32'h0109_5020; // add $10,$8,$9
    localparam logic [31:0] SUB1  = 32'h0149_5822; // sub $11,$10,$9
    localparam logic [31:0] LW8   = 32'h8C08_0004; // lw $8,4($0)
    localparam logic [31:0] LW0   = 32'h8C00_0004; // lw $0,4($0)
    localparam logic [31:0] ADD0  = 32'h0009_5020; // add $10,$0,$9
    localparam logic [31:0] W20   = 32'h0000_0020;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] instruction_in;
    logic [25:0] bundle_in;
    logic [31:0] pc_seq_in;
    logic        flush_in;

    logic        pc_enable_out;
    logic [31:0] instruction_out;
    logic [25:0] bundle_out;
    logic [31:0] pc_seq_out;
    logic [4:0]  rs_out, rt_out, rd_out, shamt_out;
    logic [15:0] imm_out;
    logic        valid_out;
    logic [15:0] stall_count_out;

    logic        s_pc_enable_out;
    logic [31:0] s_instruction_out;
    logic [25:0] s_bundle_out;
    logic [31:0] s_pc_seq_out;
    logic [4:0]  s_rs_out, s_rt_out, s_rd_out, s_shamt_out;
    logic [15:0] s_imm_out;
    logic        s_valid_out;
    logic [3:0]  s_stall_count_out;

    decode_stage dut (
        .clk(clk), .reset(reset),
        .instruction_in(instruction_in), .bundle_in(bundle_in),
        .pc_seq_in(pc_seq_in), .flush_in(flush_in),
        .pc_enable_out(pc_enable_out), .instruction_out(instruction_out),
        .bundle_out(bundle_out), .pc_seq_out(pc_seq_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out),
        .shamt_out(shamt_out), .imm_out(imm_out), .valid_out(valid_out),
        .stall_count_out(stall_count_out)
    );

    // Narrow-counter instance, driven identically, for saturation.
    decode_stage #(.STALL_CNT_WIDTH(4)) dut_sat (
        .clk(clk), .reset(reset),
        .instruction_in(instruction_in), .bundle_in(bundle_in),
        .pc_seq_in(pc_seq_in), .flush_in(flush_in),
        .pc_enable_out(s_pc_enable_out), .instruction_out(s_instruction_out),
        .bundle_out(s_bundle_out), .pc_seq_out(s_pc_seq_out),
        .rs_out(s_rs_out), .rt_out(s_rt_out), .rd_out(s_rd_out),
        .shamt_out(s_shamt_out), .imm_out(s_imm_out), .valid_out(s_valid_out),
        .stall_count_out(s_stall_count_out)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Two pipeline slots plus a running total of stall cycles; the counter
    // outputs are that total clipped at each counter's maximum.
    typedef struct {
        logic [31:0] instr;
        logic [25:0] bundle;
        logic [31:0] pc;
        logic        valid;
    } slot_t;

    slot_t m_fd, m_ex;
    int    m_stalls;

    function automatic slot_t bubble();
        slot_t s;
        s.instr = NOP; s.bundle = 26'd0; s.pc = 32'd0; s.valid = 1'b0;
        return s;
    endfunction

    function automatic logic m_hazard();
        logic [4:0] ld_dst;
        ld_dst = m_ex.instr[20:16];
        return m_fd.valid && m_ex.valid && m_ex.bundle[2] && (ld_dst != 5'd0) &&
               (ld_dst == m_fd.instr[25:21] || ld_dst == m_fd.instr[20:16]);
    endfunction

    task automatic model_reset();
        m_fd = bubble();
        m_ex = bubble();
        m_stalls = 0;
    endtask

    task automatic model_step();
        if (flush_in) begin
            m_fd = bubble();
            m_ex = bubble();
        end else if (m_hazard()) begin
            m_ex = bubble();
            m_stalls++;
        end else begin
            m_ex = m_fd;
            m_fd.instr = instruction_in; m_fd.bundle = bundle_in;
            m_fd.pc = pc_seq_in; m_fd.valid = 1'b1;
        end
    endtask

    task automatic check_model();
        int e16, e4;
        e16 = (m_stalls > 65535) ? 65535 : m_stalls;
        e4  = (m_stalls > 15) ? 15 : m_stalls;
        chk("m_instr", instruction_out, m_ex.instr);
        chk("m_bundle", {6'd0, bundle_out}, {6'd0, m_ex.bundle});
        chk("m_pc", pc_seq_out, m_ex.pc);
        chk("m_valid", {31'd0, valid_out}, {31'd0, m_ex.valid});
        chk("m_rs", {27'd0, rs_out}, {27'd0, m_ex.instr[25:21]});
        chk("m_rt", {27'd0, rt_out}, {27'd0, m_ex.instr[20:16]});
        chk("m_rd", {27'd0, rd_out}, {27'd0, m_ex.instr[15:11]});
        chk("m_shamt", {27'd0, shamt_out}, {27'd0, m_ex.instr[10:6]});
        chk("m_imm", {16'd0, imm_out}, {16'd0, m_ex.instr[15:0]});
        chk("m_pc_en", {31'd0, pc_enable_out}, {31'd0, (!m_hazard() && !reset)});
        chk("m_cnt16", {16'd0, stall_count_out}, e16);
        chk("m_cnt4", {28'd0, s_stall_count_out}, e4);
    endtask

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the next negedge.
    task automatic apply(input logic [31:0] i, input logic [25:0] b,
                         input logic [31:0] p, input logic f);
        instruction_in = i; bundle_in = b; pc_seq_in = p; flush_in = f;
        #1;
        check_model();
        model_step();
        @(negedge clk);
    endtask

    // Asserts reset asynchronously in the middle of the high phase and
    // checks the cleared outputs before any clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_instr", instruction_out, NOP);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_cnt", {16'd0, stall_count_out}, 32'd0);
        chk("rst_cnt4", {28'd0, s_stall_count_out}, 32'd0);
        chk("rst_pc_en", {31'd0, pc_enable_out}, 32'd0);
        chk("rst_pc", pc_seq_out, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic [25:0] bundle;
        logic [31:0] pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_pc_en;
        logic [4:0]  e_rs, e_rt, e_rd;
        int          e_cnt;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic [31:0] r_instr, r_pc;
        logic [25:0] r_bundle;
        logic        r_flush;

        // Expected outputs are those visible while the row's inputs are driven.
        tbl[0]  = '{ADD1, 26'd0, 32'd4,  NOP,  32'd0,  1'b0, 1'b1, 5'd0,  5'd0, 5'd0,  0};
        tbl[1]  = '{SUB1, 26'd0, 32'd8,  NOP,  32'd0,  1'b0, 1'b1, 5'd0,  5'd0, 5'd0,  0};
        tbl[2]  = '{LW8,  26'd4, 32'd12, ADD1, 32'd4,  1'b1, 1'b1, 5'd8,  5'd9, 5'd10, 0};
        tbl[3]  = '{ADD1, 26'd0, 32'd16, SUB1, 32'd8,  1'b1, 1'b1, 5'd10, 5'd9, 5'd11, 0};
        tbl[4]  = '{W20,  26'd0, 32'd20, LW8,  32'd12, 1'b1, 1'b0, 5'd0,  5'd8, 5'd0,  0};
        tbl[5]  = '{W20,  26'd0, 32'd20, NOP,  32'd0,  1'b0, 1'b1, 5'd0,  5'd0, 5'd0,  1};
        tbl[6]  = '{NOP,  26'd0, 32'd24, ADD1, 32'd16, 1'b1, 1'b1, 5'd8,  5'd9, 5'd10, 1};
        tbl[7]  = '{LW0,  26'd4, 32'd28, W20,  32'd20, 1'b1, 1'b1, 5'd0,  5'd0, 5'd0,  1};
        tbl[8]  = '{ADD0, 26'd0, 32'd32, NOP,  32'd24, 1'b1, 1'b1, 5'd0,  5'd0, 5'd0,  1};
        tbl[9]  = '{NOP,  26'd0, 32'd36, LW0,  32'd28, 1'b1, 1'b1, 5'd0,  5'd0, 5'd0,  1};
        tbl[10] = '{NOP,  26'd0, 32'd40, ADD0, 32'd32, 1'b1, 1'b1, 5'd0,  5'd9, 5'd10, 1};

        instruction_in = NOP; bundle_in = 26'd0; pc_seq_in = 32'd0; flush_in = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Straight-line, load-use and zero-destination sequence.
        for (int i = 0; i < 11; i++) begin
            instruction_in = tbl[i].instr; bundle_in = tbl[i].bundle;
            pc_seq_in = tbl[i].pc; flush_in = 1'b0;
            #1;
            chk($sformatf("tbl%0d_instr", i), instruction_out, tbl[i].e_instr);
            chk($sformatf("tbl%0d_pc", i), pc_seq_out, tbl[i].e_pc);
            chk($sformatf("tbl%0d_valid", i), {31'd0, valid_out}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d_pc_en", i), {31'd0, pc_enable_out}, {31'd0, tbl[i].e_pc_en});
            chk($sformatf("tbl%0d_rs", i), {27'd0, rs_out}, {27'd0, tbl[i].e_rs});
            chk($sformatf("tbl%0d_rt", i), {27'd0, rt_out}, {27'd0, tbl[i].e_rt});
            chk($sformatf("tbl%0d_rd", i), {27'd0, rd_out}, {27'd0, tbl[i].e_rd});
            chk($sformatf("tbl%0d_cnt", i), {16'd0, stall_count_out}, tbl[i].e_cnt);
            check_model();
            model_step();
            @(negedge clk);
        end

        // Flush arriving in the hazard cycle.
        apply(LW8, 26'd4, 32'd44, 1'b0);
        apply(ADD1, 26'd0, 32'd48, 1'b0);
        chk("fh_pc_en_low", {31'd0, pc_enable_out}, 32'd0);
        apply(W20, 26'd0, 32'd52, 1'b1);
        chk("fh_valid", {31'd0, valid_out}, 32'd0);
        chk("fh_instr", instruction_out, NOP);
        chk("fh_pc_en", {31'd0, pc_enable_out}, 32'd1);
        chk("fh_cnt", {16'd0, stall_count_out}, 32'd1);
        apply(W20, 26'd0, 32'd52, 1'b0);
        chk("fh_valid2", {31'd0, valid_out}, 32'd0);
        chk("fh_pc_en2", {31'd0, pc_enable_out}, 32'd1);
        apply(NOP, 26'd0, 32'd56, 1'b0);

        // Reset in the middle of a stall.
        apply(LW8, 26'd4, 32'd60, 1'b0);
        apply(ADD1, 26'd0, 32'd64, 1'b0);
        chk("rs_pc_en_low", {31'd0, pc_enable_out}, 32'd0);
        do_reset();
        apply(ADD1, 26'd0, 32'd4, 1'b0);
        chk("rs_after_pc_en", {31'd0, pc_enable_out}, 32'd1);
        chk("rs_after_valid", {31'd0, valid_out}, 32'd0);
        chk("rs_after_cnt", {16'd0, stall_count_out}, 32'd0);

        // Saturation: 17 load-use pairs.
        do_reset();
        for (int k = 0; k < 17; k++) begin
            apply(LW8, 26'd4, 32'd100 + 16 * k, 1'b0);
            apply(ADD1, 26'd0, 32'd104 + 16 * k, 1'b0);
            apply(NOP, 26'd0, 32'd108 + 16 * k, 1'b0);
            apply(NOP, 26'd0, 32'd112 + 16 * k, 1'b0);
            if (k == 14) chk("sat_at15", {28'd0, s_stall_count_out}, 32'd15);
        end
        chk("sat_hold15", {28'd0, s_stall_count_out}, 32'd15);
        chk("sat_wide17", {16'd0, stall_count_out}, 32'd17);

        // Randomized traffic against the model; fetch holds its word
        // while the model says pc_enable_out is low.
        do_reset();
        r_instr = NOP; r_bundle = 26'd0; r_pc = 32'd0; r_flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!m_hazard()) begin
                r_instr = {6'($urandom_range(0, 63)), 5'($urandom_range(0, 3)),
                           5'($urandom_range(0, 3)), 16'($urandom)};
                r_bundle = 26'($urandom);
                r_bundle[2] = 1'($urandom_range(0, 1));
                r_pc = r_pc + 32'd4;
            end
            r_flush = ($urandom_range(0, 9) == 0);
            apply(r_instr, r_bundle, r_pc, r_flush);
        end
        apply(NOP, 26'd0, 32'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Receiving end of the fetch interface: captures the instruction word, 26-bit control bundle and sequential PC from the fetch module into an IF/ID register. It extracts register and immediate fields and presents a registered ID/EX bundle to execute. It detects load-use hazards against the instruction it last issued and drives the fetch PC enable. It also handles flushes for taken branches and jumps, and keeps a saturating stall counter.

## Interface
Parameters:
- NOP_INSTR, 32'h3400_0000, bubble instruction word (ori $zero,$zero,0)
- STALL_CNT_WIDTH, 16, width of the stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- instruction_in  in  32  instruction word from fetch
- bundle_in  in  26  control bundle from fetch; bit 2 = data_mem_re
- pc_seq_in  in  32  PC+4 from fetch
- flush_in  in  1  taken branch or jump resolved in EX; kill younger instructions
- pc_enable_out  out  1  fetch PC/ROM advance enable
- instruction_out  out  32  ID/EX instruction
- bundle_out  out  26  ID/EX control bundle
- pc_seq_out  out  32  ID/EX PC+4
- rs_out, rt_out, rd_out  out  5 each  fields [25:21], [20:16], [15:11]
- shamt_out  out  5  field [10:6]
- imm_out  out  16  field [15:0]
- valid_out  out  1  ID/EX holds a real instruction
- stall_count_out  out  STALL_CNT_WIDTH  saturating count of load-use stall cycles

## Operation
Internal IF/ID register holds fd_instr, fd_bundle, fd_pc and fd_valid. The ID/EX register drives all `*_out` ports except pc_enable_out.

Field decode:
- Fields are taken from fd_instr combinationally.
- They are registered into ID/EX together with fd_bundle and fd_pc.

Hazard (combinational):
- hazard = fd_valid & valid_out & bundle_out[2] & (rt_out != 0) & (rt_out == fd_instr[25:21] | rt_out == fd_instr[20:16])
- The rt comparison is always made (conservative).
- Writes to $zero never stall.

pc_enable_out:
- = ~hazard & ~reset
- flush_in does not deassert it; fetch loads the redirect target via its own next-PC path.

Per rising edge, in priority order:
1. flush_in=1:
   - IF/ID loads NOP_INSTR, bundle 0, fd_valid=0.
   - ID/EX loads a bubble: NOP_INSTR, bundle 0, valid 0, fields from NOP_INSTR, pc_seq_out 0.
   - Counter is unchanged.
   - Flush overrides a concurrent hazard.
2. hazard=1:
   - IF/ID holds.
   - ID/EX loads a bubble.
   - Counter increments if below 2^STALL_CNT_WIDTH−1, else holds.
3. Otherwise:
   - IF/ID loads instruction_in, bundle_in, pc_seq_in, fd_valid=1.
   - ID/EX loads the IF/ID contents and decoded fields; valid_out = fd_valid.

A bubble in ID/EX clears bundle_out[2], so a hazard lasts exactly one cycle per load-use pair.

## Timing
- Reset (async): IF/ID and ID/EX instruction = NOP_INSTR, bundles 0, PCs 0, fd_valid=valid_out=0, fields decoded from NOP_INSTR (rs=rt=rd=shamt=0, imm=0), stall_count_out=0, pc_enable_out=0.
- First edge after reset deassertion: pc_enable_out=1.
- Latency: a word present on instruction_in before edge N appears on instruction_out after edge N+1 (2 cycles), absent stalls/flushes.
- Load-use: one bubble; the dependent instruction reaches ID/EX one edge late; pc_enable_out is low for exactly one cycle.
- Reset mid-stall: all state clears immediately; no pending stall survives.

## Test plan
- Reset: assert reset asynchronously mid-cycle -> instruction_out=32'h3400_0000, valid_out=0, stall_count_out=0, pc_enable_out=0 without waiting for a clock edge.
- Straight-line: feed 0x01095020 (add $10,$8,$9) then 0x01495822 -> each appears on instruction_out 2 edges later, valid_out=1, rs_out=8, rt_out=9, rd_out=10; pc_enable_out stays 1.
- Load-use: lw $8,4($0) (0x8C080004, bundle bit2=1) then add $10,$8,$9 -> pc_enable_out=0 for one cycle, one bubble (valid_out=0), add issues next edge, stall_count_out=1.
- Zero destination: lw $0,4($0) followed by add $10,$0,$9 -> no stall, stall_count_out stays 0.
- Flush during hazard: set up a load-use pair and assert flush_in in the hazard cycle -> ID/EX bubble, IF/ID becomes NOP with fd_valid=0, counter unchanged, no stall on the next cycle.
- Saturation: STALL_CNT_WIDTH=4, 17 load-use pairs -> stall_count_out reaches 15 and holds at 15.
